// File: rtl/elevator_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : elevator_ctrl
// Purpose  : Collective (SCAN) car scheduler. Consumes latched button
//            requests, moves the car one floor at a time, opens the door at
//            served floors and returns one-cycle clear pulses to the latch.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_ctrl #(
  parameter int BUTTONS_WIDTH = 8,
  parameter int FLOOR_WIDTH   = 3,
  parameter int FLOOR_TICKS   = 4,
  parameter int DOOR_TICKS    = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
  input  logic [BUTTONS_WIDTH-1:0] active_out_up_levels,
  input  logic [BUTTONS_WIDTH-1:0] active_out_down_levels,
  output logic [BUTTONS_WIDTH-1:0] inactive_in_levels,
  output logic [BUTTONS_WIDTH-1:0] inactive_out_up_levels,
  output logic [BUTTONS_WIDTH-1:0] inactive_out_down_levels,
  output logic [FLOOR_WIDTH-1:0]   floor,
  output logic                     dir_up,
  output logic                     moving,
  output logic                     door_open
);

  localparam int c_TCNT_W = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1;
  localparam int c_DCNT_W = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [c_TCNT_W-1:0]    c_TRAVEL_LAST = c_TCNT_W'(FLOOR_TICKS - 1);
  localparam logic [c_DCNT_W-1:0]    c_DOOR_LAST   = c_DCNT_W'(DOOR_TICKS - 1);
  localparam logic [FLOOR_WIDTH-1:0] c_TOP_FLOOR   = FLOOR_WIDTH'(BUTTONS_WIDTH - 1);
  localparam logic [BUTTONS_WIDTH-1:0] c_UP_MASK   = ~(BUTTONS_WIDTH'(1) << (BUTTONS_WIDTH - 1));
  localparam logic [BUTTONS_WIDTH-1:0] c_DN_MASK   = ~BUTTONS_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR_OPEN = 2'd3
  } state_t;

  // Bit f of v; floor codes beyond the last floor read as zero.
  function automatic logic f_bit(input logic [BUTTONS_WIDTH-1:0] v,
                                 input logic [FLOOR_WIDTH-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < BUTTONS_WIDTH; i++)
      if (FLOOR_WIDTH'(i) == f) r = v[i];
    return r;
  endfunction

  function automatic logic f_above(input logic [BUTTONS_WIDTH-1:0] v,
                                   input logic [FLOOR_WIDTH-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < BUTTONS_WIDTH; i++)
      if (FLOOR_WIDTH'(i) > f) r = r | v[i];
    return r;
  endfunction

  function automatic logic f_below(input logic [BUTTONS_WIDTH-1:0] v,
                                   input logic [FLOOR_WIDTH-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < BUTTONS_WIDTH; i++)
      if (FLOOR_WIDTH'(i) < f) r = r | v[i];
    return r;
  endfunction

  function automatic logic [BUTTONS_WIDTH-1:0] f_onehot(input logic [FLOOR_WIDTH-1:0] f);
    logic [BUTTONS_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < BUTTONS_WIDTH; i++)
      r[i] = (FLOOR_WIDTH'(i) == f);
    return r;
  endfunction

  state_t                   r_state, w_state_nxt;
  logic [FLOOR_WIDTH-1:0]   r_floor, w_floor_nxt;
  logic                     r_dir, w_dir_nxt;
  logic [c_TCNT_W-1:0]      r_tcnt, w_tcnt_nxt;
  logic [c_DCNT_W-1:0]      r_dcnt, w_dcnt_nxt;
  logic                     r_moving, r_door;
  logic [BUTTONS_WIDTH-1:0] r_pin, r_pup, r_pdn;
  logic [BUTTONS_WIDTH-1:0] w_pin, w_pup, w_pdn;

  // The end floors have no hall button pointing out of the building.
  logic [BUTTONS_WIDTH-1:0] w_in, w_up, w_dn, w_req;
  assign w_in  = active_in_levels;
  assign w_up  = active_out_up_levels & c_UP_MASK;
  assign w_dn  = active_out_down_levels & c_DN_MASK;
  assign w_req = w_in | w_up | w_dn;

  // Request summary at the current floor and at the two neighbours.
  logic [FLOOR_WIDTH-1:0] w_floor_up1, w_floor_dn1;
  logic w_here, w_above, w_below, w_clearable;
  logic w_serve_up, w_serve_dn, w_ahead_up1, w_ahead_dn1;
  assign w_floor_up1 = r_floor + FLOOR_WIDTH'(1);
  assign w_floor_dn1 = r_floor - FLOOR_WIDTH'(1);
  assign w_here      = f_bit(w_req, r_floor);
  assign w_above     = f_above(w_req, r_floor);
  assign w_below     = f_below(w_req, r_floor);
  assign w_clearable = f_bit(w_in, r_floor) |
                       (r_dir ? f_bit(w_up, r_floor) : f_bit(w_dn, r_floor));
  assign w_ahead_up1 = f_above(w_req, w_floor_up1);
  assign w_ahead_dn1 = f_below(w_req, w_floor_dn1);
  assign w_serve_up  = f_bit(w_in, w_floor_up1) | f_bit(w_up, w_floor_up1) |
                       (f_bit(w_dn, w_floor_up1) & ~w_ahead_up1);
  assign w_serve_dn  = f_bit(w_in, w_floor_dn1) | f_bit(w_dn, w_floor_dn1) |
                       (f_bit(w_up, w_floor_dn1) & ~w_ahead_dn1);

  logic                     w_decide, w_enter, w_ahead_entry;
  logic [BUTTONS_WIDTH-1:0] w_oh;

  // Next-state, counters, direction and clear-pulse generation.
  always_comb begin
    w_state_nxt   = r_state;
    w_floor_nxt   = r_floor;
    w_dir_nxt     = r_dir;
    w_tcnt_nxt    = r_tcnt;
    w_dcnt_nxt    = r_dcnt;
    w_pin         = '0;
    w_pup         = '0;
    w_pdn         = '0;
    w_decide      = 1'b0;
    w_enter       = 1'b0;
    w_ahead_entry = 1'b0;
    w_oh          = '0;

    case (r_state)
      ST_IDLE: w_decide = 1'b1;
      ST_MOVE_UP: begin
        if (r_tcnt == c_TRAVEL_LAST) begin
          w_tcnt_nxt = '0;
          if (r_floor == c_TOP_FLOOR) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_floor_nxt = w_floor_up1;
            if (w_serve_up)        w_enter     = 1'b1;
            else if (!w_ahead_up1) w_state_nxt = ST_IDLE;
          end
        end else begin
          w_tcnt_nxt = r_tcnt + c_TCNT_W'(1);
        end
      end
      ST_MOVE_DOWN: begin
        if (r_tcnt == c_TRAVEL_LAST) begin
          w_tcnt_nxt = '0;
          if (r_floor == '0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_floor_nxt = w_floor_dn1;
            if (w_serve_dn)        w_enter     = 1'b1;
            else if (!w_ahead_dn1) w_state_nxt = ST_IDLE;
          end
        end else begin
          w_tcnt_nxt = r_tcnt + c_TCNT_W'(1);
        end
      end
      ST_DOOR_OPEN: begin
        if (r_dcnt == c_DOOR_LAST) begin
          w_dcnt_nxt = '0;
          if (w_clearable) w_enter  = 1'b1;
          else             w_decide = 1'b1;
        end else begin
          w_dcnt_nxt = r_dcnt + c_DCNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Idle-style choice: serve here, else follow the preferred direction.
    if (w_decide) begin
      w_state_nxt = ST_IDLE;
      if (w_here) begin
        w_enter = 1'b1;
      end else if (w_above && (r_dir || !w_below)) begin
        w_state_nxt = ST_MOVE_UP;
        w_dir_nxt   = 1'b1;
        w_tcnt_nxt  = '0;
      end else if (w_below) begin
        w_state_nxt = ST_MOVE_DOWN;
        w_dir_nxt   = 1'b0;
        w_tcnt_nxt  = '0;
      end
    end

    // Door entry clears the served buttons and reverses at the end of a sweep.
    if (w_enter) begin
      w_state_nxt   = ST_DOOR_OPEN;
      w_dcnt_nxt    = '0;
      w_tcnt_nxt    = '0;
      w_oh          = f_onehot(w_floor_nxt);
      w_pin         = w_oh & w_in;
      w_ahead_entry = r_dir ? f_above(w_req, w_floor_nxt) : f_below(w_req, w_floor_nxt);
      if (r_dir) w_pup = w_oh & w_up;
      else       w_pdn = w_oh & w_dn;
      if (!w_ahead_entry) begin
        w_dir_nxt = ~r_dir;
        if (r_dir) w_pdn = w_oh & w_dn;
        else       w_pup = w_oh & w_up;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_floor  <= '0;
      r_dir    <= 1'b1;
      r_tcnt   <= '0;
      r_dcnt   <= '0;
      r_moving <= 1'b0;
      r_door   <= 1'b0;
      r_pin    <= '0;
      r_pup    <= '0;
      r_pdn    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_floor  <= w_floor_nxt;
      r_dir    <= w_dir_nxt;
      r_tcnt   <= w_tcnt_nxt;
      r_dcnt   <= w_dcnt_nxt;
      r_moving <= (w_state_nxt == ST_MOVE_UP) || (w_state_nxt == ST_MOVE_DOWN);
      r_door   <= (w_state_nxt == ST_DOOR_OPEN);
      r_pin    <= w_pin;
      r_pup    <= w_pup;
      r_pdn    <= w_pdn;
    end
  end

  assign floor                    = r_floor;
  assign dir_up                   = r_dir;
  assign moving                   = r_moving;
  assign door_open                = r_door;
  assign inactive_in_levels       = r_pin;
  assign inactive_out_up_levels   = r_pup;
  assign inactive_out_down_levels = r_pdn;

endmodule
`default_nettype wire

// File: doc/elevator_ctrl.md
Name: elevator_ctrl

Overview:
- Car scheduler that sits directly downstream of the button latch block.
- Consumes the latched request vectors active_in_levels, active_out_up_levels and active_out_down_levels.
- Moves the car one floor at a time using the standard collective (SCAN) policy: keep going while requests remain ahead, then reverse.
- Opens the door at served floors and returns one-cycle clear pulses (inactive_*) to the button block.

Parameters:
- BUTTONS_WIDTH, 8: number of floors; bit i = floor i, floor 0 lowest.
- FLOOR_WIDTH, 3: width of the floor index; must satisfy 2^FLOOR_WIDTH >= BUTTONS_WIDTH.
- FLOOR_TICKS, 4: clock cycles to travel one floor, >= 1.
- DOOR_TICKS, 6: clock cycles the door stays open, >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- active_in_levels  in  BUTTONS_WIDTH  latched in-car requests.
- active_out_up_levels  in  BUTTONS_WIDTH  latched hall-up requests.
- active_out_down_levels  in  BUTTONS_WIDTH  latched hall-down requests.
- inactive_in_levels  out  BUTTONS_WIDTH  one-cycle clear pulse, in-car requests.
- inactive_out_up_levels  out  BUTTONS_WIDTH  one-cycle clear pulse, hall-up requests.
- inactive_out_down_levels  out  BUTTONS_WIDTH  one-cycle clear pulse, hall-down requests.
- floor  out  FLOOR_WIDTH  current car floor.
- dir_up  out  1  travel direction: 1 = up, 0 = down.
- moving  out  1  high in MOVE_UP and MOVE_DOWN.
- door_open  out  1  high in DOOR_OPEN.

Behaviour:
- All outputs are registered.
- Reset: state IDLE; floor=0; dir_up=1; moving=0; door_open=0; all inactive_* = 0; travel and door counters = 0. Reset takes effect mid-move or mid-door with no clear pulses emitted.
- Input masking: active_out_down_levels[0] and active_out_up_levels[BUTTONS_WIDTH-1] are ignored. Bits at or above BUTTONS_WIDTH in the floor decode are ignored.
- Derived terms, where f = floor:
  - req = in | up | down, after masking.
  - above = any req bit > f.
  - below = any req bit < f.
  - here = req[f].
- IDLE:
  - If here, go to DOOR_OPEN.
  - Else if above, go to MOVE_UP with dir_up=1.
  - Else if below, go to MOVE_DOWN with dir_up=0.
  - Else stay in IDLE.
  - Above takes priority over below when dir_up=1; below takes priority when dir_up=0.
- MOVE_UP / MOVE_DOWN:
  - The travel counter counts from 0. On the edge where it equals FLOOR_TICKS-1, floor increments (up) or decrements (down) and the counter clears. The floor therefore changes FLOOR_TICKS cycles after entering the move state.
  - On that same edge, evaluate the serve condition at the new floor f':
    - Moving up: in[f'] | up[f'] | (down[f'] & no req above f').
    - Moving down: mirror image.
  - If the serve condition holds, go to DOOR_OPEN. Else if requests remain ahead, keep moving. Else go to IDLE; this is reached only if requests vanished, e.g. were cleared externally.
  - The floor never leaves 0..BUTTONS_WIDTH-1; the car stops at the end floors.
- Entering DOOR_OPEN (same edge):
  - door_open=1.
  - Pulse inactive_in_levels[f] if in[f].
  - Pulse the same-direction hall bit if set.
  - If no req lies ahead in the current direction, flip dir_up and also pulse the opposite hall bit if set.
  - Pulses last exactly one cycle and are one-hot at bit f. No pulse is issued for bits that are not active.
- DOOR_OPEN:
  - The door counter runs DOOR_TICKS cycles; door_open is high for exactly DOOR_TICKS cycles.
  - At expiry, if a clearable request exists at f (in, or hall bit in the current direction), re-enter DOOR_OPEN: new pulse and counter restarts.
  - Otherwise apply the IDLE decision with the current dir_up preference; door_open drops on that edge.
- moving and door_open are never high together. inactive_* is nonzero only on the first cycle of a DOOR_OPEN entry.
- A request pressed for the current floor while moving past is not served; the floor has already updated.

Test Plan:
- Reset, then in[3]=1 (8'b00001000) from IDLE at floor 0 → moving=1 next edge; floor steps 1, 2, 3 at +4, +8, +12 edges. On reaching floor 3: door_open=1 and inactive_in_levels=8'h08 for one cycle; door_open high 6 cycles; then IDLE.
- At floor 0, set up[4]=1 and down[7]=1 → stop at 4 with inactive_out_up_levels=8'h10 pulse; continue to 7 with inactive_out_down_levels=8'h80 pulse and dir_up=0.
- Moving up past floor 2 with down[2]=1 and in[5]=1 → no stop at 2; serve 5; reverse; serve 2 with inactive_out_down_levels=8'h04.
- Door open at floor 5, in[5] asserted mid-door → second clear pulse 8'h20 at door expiry; door_open stays high a further 6 cycles.
- reset=1 while moving between floors 2 and 3 → next edge: floor=0, moving=0, IDLE, no inactive_* pulses.
- down[0]=1 and up[7]=1 only, from IDLE → both masked; state stays IDLE, no motion, no pulses.
